// File: rtl/prog_loader.sv
// Host-side program loader: streams instruction words into instruction memory,
// holds the processor in init while loading, then runs it and times it until halt.
module prog_loader #(
  parameter int IW           = 9,
  parameter int AW           = 10,
  parameter int CW           = 16,
  parameter int START_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          go,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_wdata,
  output logic          cpu_start,
  input  logic          cpu_halt,
  input  logic [CW-1:0] max_cycles,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          overflow,
  output logic [CW-1:0] cycles,
  output logic [2:0]    dbg_state
);

  // Stream handshake: a word transfers on a rising CLK edge where in_valid and
  // in_ready are both high; in_ready is a pure function of state and never
  // depends on in_valid, and in_data/in_last are only sampled on a transfer.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SCW-1:0] START_LAST = SCW'((START_CYCLES > 0) ? START_CYCLES - 1 : 0);
  localparam logic [AW-1:0]  PTR_MAX    = '1;
  localparam logic [CW-1:0]  CYC_MAX    = '1;

  state_t         state_q, state_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic           we_q, we_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [IW-1:0]  wdata_q, wdata_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [CW-1:0]  cycles_q, cycles_d;
  logic           timeout_q, timeout_d;
  logic           overflow_q, overflow_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    scnt_d     = scnt_q;
    cycles_d   = cycles_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d    = S_LOAD;
          ptr_d      = '0;
          cycles_d   = '0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = in_data;
          // The pointer never wraps: the top address ends the load even without in_last.
          if (in_last || (ptr_q == PTR_MAX)) begin
            state_d    = S_START;
            scnt_d     = '0;
            overflow_d = !in_last;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      S_START: begin
        if (scnt_q == START_LAST) begin
          state_d  = S_RUN;
          cycles_d = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // Halt takes priority over a coincident timeout and freezes the count.
        if (cpu_halt) begin
          state_d = S_DONE;
        end else if ((max_cycles != '0) && (cycles_q == max_cycles)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (cycles_q != CYC_MAX) begin
          cycles_d = cycles_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_START) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      scnt_q     <= '0;
      cycles_q   <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      scnt_q     <= scnt_d;
      cycles_q   <= cycles_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign cpu_start = (state_q != S_RUN) && (state_q != S_DONE);
  assign im_we     = we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign overflow  = overflow_q;
  assign cycles    = cycles_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: vector table of load/run scenarios, write scoreboard
// tagged with the expected cycle, plus hand-written reset/overflow sequences.
module tb_prog_loader;

  localparam int IW = 9;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int W  = 32 + AW + IW;

  logic          CLK = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [IW-1:0] im_wdata;
  logic          cpu_start;
  logic          cpu_halt = 1'b0;
  logic [CW-1:0] max_cycles = '0;
  logic          busy, done, timeout, overflow;
  logic [CW-1:0] cycles;
  logic [2:0]    dbg_state;

  prog_loader #(.IW(IW), .AW(AW), .CW(CW), .START_CYCLES(2)) dut (
    .CLK(CLK), .reset_n(reset_n), .go(go), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_start(cpu_start), .cpu_halt(cpu_halt),
    .max_cycles(max_cycles), .busy(busy), .done(done), .timeout(timeout),
    .overflow(overflow), .cycles(cycles), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 CLK = ~CLK;
  int pcnt = 0;
  always @(posedge CLK) pcnt <= pcnt + 1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] wp = '0;
  logic [IW-1:0] words[1024];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: each observed write must match the oldest expected {cycle, addr, data}
  always @(negedge CLK) begin
    if (im_we) begin
      if (exp_q.size() == 0) begin
        chk("extra_write_im_we", im_we, 0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", im_addr, e[IW +: AW]);
        chk("wr_data", im_wdata, e[IW-1:0]);
        chk("wr_cycle", pcnt, e[W-1 -: 32]);
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_cpu_start"}, cpu_start, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_im_we"}, im_we, 0);
    chk({tag, "_im_addr"}, im_addr, 0);
    chk({tag, "_im_wdata"}, im_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_cycles"}, cycles, 0);
  endtask

  // driver tasks; all are entered and left at a negedge
  task automatic begin_load();
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    wp = '0;
    chk("load_busy", busy, 1);
    chk("load_done", done, 0);
    chk("load_in_ready", in_ready, 1);
    chk("load_cpu_start", cpu_start, 1);
    chk("go_clr_timeout", timeout, 0);
    chk("go_clr_overflow", overflow, 0);
    chk("go_clr_cycles", cycles, 0);
  endtask

  task automatic load_words(input int n, input bit use_last, input bit gaps, input bit go_noise);
    int i = 0;
    int budget = 0;
    while (i < n) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = words[i];
      in_last  = use_last && (i == n - 1);
      go       = go_noise && (i > 0) && ($urandom_range(0, 7) == 0);
      if (in_valid && in_ready) begin
        exp_q.push_back({32'(pcnt + 1), wp, words[i]});
        wp = wp + 1'b1;
        i++;
      end
      @(negedge CLK);
      budget++;
      if (budget > 20000) begin
        chk("load_budget", budget, 0);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    go       = 1'b0;
  endtask

  // first negedge here shows the final write; cpu_start must stay high two cycles
  task automatic start_seq(input bit offer_extra, input bit halt_in_start, input bit exp_ovf);
    chk("start0_cpu_start", cpu_start, 1);
    chk("start0_in_ready", in_ready, 0);
    chk("start0_busy", busy, 1);
    chk("start0_overflow", overflow, exp_ovf);
    in_valid = offer_extra;
    in_data  = 9'h1FF;
    cpu_halt = halt_in_start;
    @(negedge CLK);
    chk("start1_cpu_start", cpu_start, 1);
    chk("start1_in_ready", in_ready, 0);
    @(negedge CLK);
    in_valid = 1'b0;
    chk("run_cpu_start", cpu_start, 0);
    chk("run_busy", busy, 1);
  endtask

  task automatic run_prog(input int halt_after, input bit go_noise);
    int k = 0;
    forever begin
      cpu_halt = (k == halt_after);
      go       = go_noise && (k == 3);
      @(negedge CLK);
      if (done) break;
      k++;
      if (k > 5000) begin
        chk("run_budget", k, 0);
        break;
      end
    end
    cpu_halt = 1'b0;
    go       = 1'b0;
  endtask

  typedef struct {
    logic [CW-1:0] max_cyc;
    int            halt_after;   // -1 = never halt
    int            n_words;
    bit            use_last;
    bit            gaps;
    bit            go_noise;
    int            exp_cycles;
    bit            exp_timeout;
    bit            exp_overflow;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'd0,  37,   4, 1'b1, 1'b0, 1'b0, 37, 1'b0, 1'b0};
    vecs[1] = '{16'd10, -1,   4, 1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b0};
    vecs[2] = '{16'd0,   0,   4, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b0};
    vecs[3] = '{16'd5,   5,   4, 1'b1, 1'b0, 1'b0,  5, 1'b0, 1'b0};
    vecs[4] = '{16'd0,  12,  40, 1'b1, 1'b1, 1'b1, 12, 1'b0, 1'b0};
    vecs[5] = '{16'd0,   3, 1024, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1};
    vecs[6] = '{16'd1,  -1,   2, 1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b0};

    #1;
    check_reset("rst_async");
    repeat (2) @(negedge CLK);
    check_reset("rst_held");
    #2 reset_n = 1'b1;
    @(negedge CLK);
    check_reset("idle");

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 1024; i++) words[i] = IW'($urandom_range(0, 511));
      if (vecs[v].n_words == 4) begin
        words[0] = 9'h1A0; words[1] = 9'h055; words[2] = 9'h0FF; words[3] = 9'h100;
      end
      max_cycles = vecs[v].max_cyc;
      begin_load();
      load_words(vecs[v].n_words, vecs[v].use_last, vecs[v].gaps, vecs[v].go_noise);
      start_seq(!vecs[v].use_last, vecs[v].halt_after == 0, vecs[v].exp_overflow);
      run_prog(vecs[v].halt_after, vecs[v].go_noise);
      chk($sformatf("v%0d_done", v), done, 1);
      chk($sformatf("v%0d_busy", v), busy, 0);
      chk($sformatf("v%0d_cpu_start", v), cpu_start, 0);
      chk($sformatf("v%0d_cycles", v), cycles, vecs[v].exp_cycles);
      chk($sformatf("v%0d_timeout", v), timeout, vecs[v].exp_timeout);
      chk($sformatf("v%0d_overflow", v), overflow, vecs[v].exp_overflow);
      repeat (3) @(negedge CLK);
      chk($sformatf("v%0d_hold_cycles", v), cycles, vecs[v].exp_cycles);
      chk($sformatf("v%0d_hold_done", v), done, 1);
    end

    // reset in the middle of a load, right as the second write is on the bus
    for (int i = 0; i < 4; i++) words[i] = IW'($urandom_range(0, 511));
    begin_load();
    load_words(2, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_reset("rst_mid");
    repeat (2) @(negedge CLK);
    check_reset("rst_mid_held");
    #2 reset_n = 1'b1;
    @(negedge CLK);
    max_cycles = '0;
    begin_load();
    load_words(4, 1'b1, 1'b1, 1'b0);
    start_seq(1'b0, 1'b0, 1'b0);
    run_prog(2, 1'b0);
    chk("restart_cycles", cycles, 2);
    chk("restart_done", done, 1);

    repeat (2) @(negedge CLK);
    chk("pending_writes", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
